regfile_sb: RTL

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 120 ++++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// Register file with per-register pending scoreboard, write forwarding and a
// post-reset clear sweep that zeroes every entry before ready rises.
module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRP   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic [NRP*AW-1:0]   ra,
  output logic [NRP*XLEN-1:0] rd,
  output logic [NRP-1:0]      busy,
  output logic                ready
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  logic [0:0]      state_r;
  logic [AW-1:0]   idx_r;
  logic [XLEN-1:0] mem_r [NREGS];
  logic [NREGS-1:0] pending_r;
  logic [NREGS-1:0] pending_nxt_s;
  logic            wr_en_s;
  logic            iss_en_s;

  assign wr_en_s  = (state_r == ST_RUN) && we && (wa != {AW{1'b0}});
  assign iss_en_s = (state_r == ST_RUN) && iss_valid && (iss_rd != {AW{1'b0}});
  assign ready    = (state_r == ST_RUN);

  // Sweep counter and INIT/RUN sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_INIT;
      idx_r   <= {AW{1'b0}};
    end else begin
      case (state_r)
        ST_INIT: begin
          idx_r <= idx_r + AW'(1);
          if (idx_r == LAST_IDX) begin
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          state_r <= ST_RUN;
        end
        default: begin
          state_r <= ST_INIT;
          idx_r   <= {AW{1'b0}};
        end
      endcase
    end
  end

  // Storage: zeroed by the sweep, written by write-back in RUN
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_r == ST_INIT) begin
        mem_r[idx_r] <= {XLEN{1'b0}};
      end else if (wr_en_s) begin
        mem_r[wa] <= wd;
      end
    end
  end

  // Next scoreboard: clear on write-back, then set on issue so set wins
  always_comb begin
    pending_nxt_s = pending_r;
    if (wr_en_s) begin
      pending_nxt_s[wa] = 1'b0;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
    if (iss_en_s) begin
      pending_nxt_s[iss_rd] = 1'b1;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
    pending_nxt_s[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r <= {NREGS{1'b0}};
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  // Combinational read ports with same-cycle write-back forwarding
  always_comb begin
    logic [AW-1:0] a;
    logic          hit;
    rd   = {(NRP*XLEN){1'b0}};
    busy = {NRP{1'b0}};
    for (int p = 0; p < NRP; p++) begin
      a   = ra[p*AW +: AW];
      hit = we && (wa == a);
      if ((state_r != ST_RUN) || (a == {AW{1'b0}})) begin
        rd[p*XLEN +: XLEN] = {XLEN{1'b0}};
        busy[p]            = 1'b0;
      end else if (hit) begin
        rd[p*XLEN +: XLEN] = wd;
        busy[p]            = 1'b0;
      end else begin
        rd[p*XLEN +: XLEN] = mem_r[a];
        busy[p]            = pending_r[a];
      end
    end
  end

endmodule
